// File: rtl/sort_pkg.sv
// Shared definitions for the sorter MMIO staging buffer: sizes, register offsets,
// CTRL/STATUS bit positions and the FSM state type.
package sort_pkg;

    localparam int unsigned N_WORDS = 32;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned IDX_W   = $clog2(N_WORDS);
    localparam int unsigned LCNT_W  = $clog2(N_WORDS + 1);

    localparam logic [8:0] OFF_IN     = 9'h000;
    localparam logic [8:0] OFF_CTRL   = 9'h080;
    localparam logic [8:0] OFF_STATUS = 9'h084;
    localparam logic [8:0] OFF_RES    = 9'h100;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_CLEAR = 1;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_OVERRUN = 2;
    localparam int unsigned STAT_TIMEOUT = 3;
    localparam int unsigned STAT_COUNT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SORTING,
        ST_DONE
    } sort_state_t;

    typedef logic [N_WORDS-1:0][WORD_W-1:0] word_vec_t;

    function automatic logic [LCNT_W-1:0] popcount(input logic [N_WORDS-1:0] m);
        logic [LCNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(N_WORDS); i++) begin
            acc = acc + LCNT_W'(m[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/sort_mmio_decode.sv
// Address decode for the 512-byte window: region selects, word index and read mux.
module sort_mmio_decode
    import sort_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_1000
) (
    input  logic [31:0]      dataadr,
    input  word_vec_t        in_buf,
    input  word_vec_t        res_buf,
    input  logic [31:0]      status,
    output logic             sel_in,
    output logic             sel_ctrl,
    output logic [IDX_W-1:0] word_idx,
    output logic [31:0]      readdata
);

    logic       in_win;
    logic       sel_status;
    logic       sel_res;
    logic [8:0] off;
    logic       unused_lsbs;

    // Byte lane bits never select anything.
    assign unused_lsbs = ^dataadr[1:0];

    always_comb begin
        in_win     = (dataadr[31:9] == BASE[31:9]);
        off        = dataadr[8:0];
        sel_in     = in_win && (off[8:7] == OFF_IN[8:7]);
        sel_res    = in_win && (off[8:7] == OFF_RES[8:7]);
        sel_ctrl   = in_win && (off[8:2] == OFF_CTRL[8:2]);
        sel_status = in_win && (off[8:2] == OFF_STATUS[8:2]);
        word_idx   = off[6:2];
        readdata   = '0;
        if (sel_in) begin
            readdata = in_buf[word_idx];
        end else if (sel_status) begin
            readdata = status;
        end else if (sel_res) begin
            readdata = res_buf[word_idx];
        end
    end

endmodule

// File: rtl/sort_mmio_buffer.sv
// MMIO staging buffer around the 32x32 sorting network: captures input words,
// launches the sorter, latches its result and reports status/overrun/timeout.
module sort_mmio_buffer
    import sort_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h0000_1000,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        memwrite,
    input  logic [31:0]                 dataadr,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic [N_WORDS*WORD_W-1:0]   sort_in,
    output logic                        sort_start,
    input  logic [N_WORDS*WORD_W-1:0]   sort_out,
    input  logic                        sort_valid
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT);

    sort_state_t       state;
    word_vec_t         in_buf;
    word_vec_t         res_buf;
    logic [N_WORDS-1:0] mask;
    logic [TCNT_W-1:0] tcnt;
    logic              done;
    logic              overrun;
    logic              timeout;
    logic [31:0]       status_c;
    logic              sel_in;
    logic              sel_ctrl;
    logic [IDX_W-1:0]  word_idx;
    logic              in_wr;
    logic              ctrl_wr;

    assign sort_in = in_buf;
    assign in_wr   = memwrite && sel_in;
    assign ctrl_wr = memwrite && sel_ctrl;

    always_comb begin
        status_c = '0;
        status_c[STAT_BUSY]    = (state == ST_SORTING);
        status_c[STAT_DONE]    = done;
        status_c[STAT_OVERRUN] = overrun;
        status_c[STAT_TIMEOUT] = timeout;
        status_c[STAT_COUNT +: LCNT_W] = popcount(mask);
    end

    sort_mmio_decode #(.BASE(BASE)) u_decode (
        .dataadr  (dataadr),
        .in_buf   (in_buf),
        .res_buf  (res_buf),
        .status   (status_c),
        .sel_in   (sel_in),
        .sel_ctrl (sel_ctrl),
        .word_idx (word_idx),
        .readdata (readdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            in_buf     <= '0;
            res_buf    <= '0;
            mask       <= '0;
            tcnt       <= '0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
            sort_start <= 1'b0;
        end else begin
            sort_start <= 1'b0;
            case (state)
                ST_SORTING: begin
                    // Buffer is frozen while the sorter consumes it; CTRL is ignored.
                    if (in_wr) begin
                        overrun <= 1'b1;
                    end
                    if (sort_valid) begin
                        res_buf <= sort_out;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    if (in_wr) begin
                        in_buf[word_idx] <= writedata;
                        mask[word_idx]   <= 1'b1;
                    end
                    // CLEAR is applied before START when both bits are written.
                    if (ctrl_wr && writedata[CTRL_CLEAR]) begin
                        mask    <= '0;
                        overrun <= 1'b0;
                        timeout <= 1'b0;
                        done    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                    if (ctrl_wr && writedata[CTRL_START]) begin
                        state      <= ST_SORTING;
                        sort_start <= 1'b1;
                        tcnt       <= '0;
                        done       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_mmio_buffer.sv
// Directed bench for sort_mmio_buffer with a cycle-level reference model of the register map.
module tb_sort_mmio_buffer;
    import sort_pkg::*;

    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam int unsigned TIMEOUT = 64;
    localparam logic [31:0] A_CTRL  = BASE + 32'h080;
    localparam logic [31:0] A_STAT  = BASE + 32'h084;
    localparam logic [31:0] A_RES   = BASE + 32'h100;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      memwrite = 1'b0;
    logic [31:0]               dataadr = '0;
    logic [31:0]               writedata = '0;
    logic [31:0]               readdata;
    logic [N_WORDS*WORD_W-1:0] sort_in;
    logic                      sort_start;
    logic [N_WORDS*WORD_W-1:0] sort_out = '0;
    logic                      sort_valid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    sort_mmio_buffer #(.BASE(BASE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .readdata   (readdata),
        .sort_in    (sort_in),
        .sort_start (sort_start),
        .sort_out   (sort_out),
        .sort_valid (sort_valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_in  [N_WORDS];
    logic [31:0] m_res [N_WORDS];
    logic [31:0] m_mask;
    logic        m_busy, m_done, m_ovr, m_tmo, m_start;
    longint      m_cyc = 0;
    longint      m_t0  = 0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        if (a < BASE || a >= BASE + 32'd512) return 32'd0;
        off = (a - BASE) & ~32'd3;
        if (off < 32'd128) return m_in[off / 4];
        if (off == 32'd132)
            return {18'd0, 6'($countones(m_mask)), 4'd0, m_tmo, m_ovr, m_done, m_busy};
        if (off >= 32'd256 && off < 32'd384) return m_res[(off - 32'd256) / 4];
        return 32'd0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic        was_busy;
        logic [31:0] off;
        logic        hit;
        if (!reset_n) begin
            for (int i = 0; i < int'(N_WORDS); i++) begin
                m_in[i]  = '0;
                m_res[i] = '0;
            end
            m_mask = '0; m_busy = 0; m_done = 0; m_ovr = 0; m_tmo = 0; m_start = 0;
        end else begin
            m_cyc++;
            was_busy = m_busy;
            m_start  = 0;
            hit = memwrite && dataadr >= BASE && dataadr < BASE + 32'd512;
            off = (dataadr - BASE) & ~32'd3;
            if (was_busy) begin
                if (hit && off < 32'd128) m_ovr = 1;
                if (sort_valid) begin
                    for (int i = 0; i < int'(N_WORDS); i++) m_res[i] = sort_out[i*32 +: 32];
                    m_done = 1; m_busy = 0;
                end else if (m_cyc - m_t0 == longint'(TIMEOUT)) begin
                    m_busy = 0; m_tmo = 1;
                end
            end else if (hit) begin
                if (off < 32'd128) begin
                    m_in[off / 4]   = writedata;
                    m_mask[off / 4] = 1'b1;
                end else if (off == 32'd128) begin
                    if (writedata[1]) begin
                        m_mask = '0; m_ovr = 0; m_tmo = 0; m_done = 0;
                    end
                    if (writedata[0]) begin
                        m_busy = 1; m_done = 0; m_start = 1; m_t0 = m_cyc;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, shortly after the edge, the DUT must agree with the model.
    always @(posedge clk) begin
        int bad_w;
        #1;
        chk("cyc_readdata", readdata, m_read(dataadr));
        chk("cyc_sort_start", 32'(sort_start), 32'(m_start));
        bad_w = -1;
        for (int i = N_WORDS - 1; i >= 0; i--) if (sort_in[i*32 +: 32] !== m_in[i]) bad_w = i;
        n_cmp++;
        if (bad_w >= 0) begin
            n_bad++;
            $display("FAIL cyc_sort_in word %0d: got 0x%08h expected 0x%08h at %0t",
                     bad_w, sort_in[bad_w*32 +: 32], m_in[bad_w], $time);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        dataadr = a;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic sorter(input int delay, input int bias);
        repeat (delay) @(negedge clk);
        for (int i = 0; i < int'(N_WORDS); i++) sort_out[i*32 +: 32] = 32'(i + bias);
        sort_valid = 1'b1;
        @(negedge clk);
        sort_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd("rst_status", A_STAT, 32'h0);
        rd("rst_in0", BASE, 32'h0);
        chk("rst_sort_start", 32'(sort_start), 32'h0);

        // Timeout with sort_valid held low
        wr(A_CTRL, 32'h1);
        chk("to_start_pulse", 32'(sort_start), 32'h1);
        rd("to_status0", A_STAT, 32'h0001);
        repeat (63) @(negedge clk);
        rd("to_busy_63", A_STAT, 32'h0001);
        @(negedge clk);
        rd("to_flag_64", A_STAT, 32'h0008);
        rd("to_res0", A_RES, 32'h0);
        rd("to_res31", A_RES + 32'd124, 32'h0);
        wr(A_CTRL, 32'h2);
        rd("clr_status", A_STAT, 32'h0);

        // Load 31..0 and sort
        for (int i = 0; i < 32; i++) wr(BASE + 32'(4 * i), 32'(31 - i));
        rd("load_count", A_STAT, 32'h2000);
        wr(A_CTRL, 32'h1);
        chk("load_start_pulse", 32'(sort_start), 32'h1);
        sorter(2, 0);
        rd("sort_status", A_STAT, 32'h2002);
        for (int i = 28; i < 32; i++) rd("sort_res", A_RES + 32'(4 * i), 32'(i));

        // Overrun while sorting
        wr(A_CTRL, 32'h1);
        rd("ovr_busy", A_STAT, 32'h2001);
        wr(BASE + 32'd20, 32'hDEAD);
        rd("ovr_word5", BASE + 32'd20, 32'd26);
        sorter(1, 0);
        rd("ovr_status", A_STAT, 32'h2006);
        wr(A_CTRL, 32'h2);
        rd("ovr_clear", A_STAT, 32'h0);

        // Partial load after a fresh reset
        do_reset();
        wr(BASE, 32'hA5A5_0000);
        wr(BASE + 32'd124, 32'h1234_5678);
        rd("part_count", A_STAT, 32'h0200);
        wr(A_CTRL, 32'h1);
        chk("part_w0", sort_in[31:0], 32'hA5A5_0000);
        chk("part_w31", sort_in[1023:992], 32'h1234_5678);
        chk("part_w1", sort_in[63:32], 32'h0);
        chk("part_w15", sort_in[511:480], 32'h0);
        sorter(2, 0);
        rd("part_status", A_STAT, 32'h0202);

        // START and CLEAR together
        wr(A_CTRL, 32'h3);
        rd("sc_status", A_STAT, 32'h0001);
        sorter(2, 0);
        rd("sc_done", A_STAT, 32'h0002);

        // Unmapped and read-only regions
        wr(BASE + 32'h200, 32'hFFFF);
        rd("unmapped_200", BASE + 32'h200, 32'h0);
        rd("unmapped_088", BASE + 32'h088, 32'h0);
        rd("ctrl_wo", A_CTRL, 32'h0);
        wr(A_RES + 32'd4, 32'h55);
        rd("res_ro", A_RES + 32'd4, 32'h1);

        // Asynchronous reset in the middle of a sort
        wr(A_CTRL, 32'h1);
        chk("ar_start_pulse", 32'(sort_start), 32'h1);
        dataadr = A_RES + 32'd4;
        #2 reset_n = 1'b0;
        #1;
        chk("ar_sort_start", 32'(sort_start), 32'h0);
        chk("ar_readdata", readdata, 32'h0);
        chk("ar_sort_in_w0", sort_in[31:0], 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        sorter(0, 100);
        rd("ar_res5", A_RES + 32'd20, 32'h0);
        rd("ar_status", A_STAT, 32'h0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
